vc_pop_scheduler: RTL and testbench
===================================

VC_POP_SCHEDULER -- requirements
Module: vc_pop_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, width of each source/destination data word.
REQ-002 SHALL have parameter RR_START, default 0, source index holding round-robin priority after reset/init.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: init  input  1  synchronous request to re-enter INIT state.
REQ-006 SHALL have ports: fifo_empty  input  4  per-source FIFO empty flags, bit i = source i.
REQ-007 SHALL have ports: data_in_0..data_in_3  input  DATA_WIDTH each  first-word-fall-through head of source i, valid when fifo_empty[i]=0.
REQ-008 SHALL have ports: out_almost_full  input  1  destination FIFO can accept at most one more word.
REQ-009 SHALL have ports: pop  output  4  one-hot-or-zero pop strobes to sources; also drive the per-source pop counters.
REQ-010 SHALL have ports: push  output  1  write strobe to destination FIFO.
REQ-011 SHALL have ports: data_out  output  DATA_WIDTH  word written with push.
REQ-012 SHALL have ports: grant_idx  output  3  index of source granted this cycle, 3'b111 when none.
REQ-013 SHALL have ports: idle  output  1  high in IDLE state; qualifies counter readout.
REQ-014 SHALL have ports: state  output  2  current state encoding.

Function
REQ-015 SHALL implement states RESET=2'b00, INIT=2'b01, IDLE=2'b10, ACTIVE=2'b11.
REQ-016 SHALL transition RESET->INIT on first cycle with reset=0; INIT->IDLE unconditionally after one cycle; any state->INIT when init=1 (reset dominates init).
REQ-017 SHALL transition IDLE->ACTIVE when any fifo_empty bit is 0; ACTIVE->IDLE when fifo_empty=4'b1111 and no pop issued that cycle.
REQ-018 SHALL issue pops only in ACTIVE state and only when out_almost_full=0 sampled in the same cycle.
REQ-019 SHALL pop at most one source per cycle; pop is combinational from registered state and current inputs.
REQ-020 SHALL select, in round-robin mode, the first nonempty source at or after the priority pointer, wrapping 3->0; pointer advances to granted index+1 (mod 4) after each grant, unchanged when no grant.
REQ-021 SHALL register push=1 and data_out=data_in_<granted> on the edge ending the pop cycle (latency one cycle pop->push); push=0 otherwise; data_out holds its last value when push=0.
REQ-022 SHALL never pop a source whose fifo_empty bit is 1, even if the pointer points at it.
REQ-023 SHALL drive grant_idx combinationally with pop: binary index of the popped source, 3'b111 when pop=0.
REQ-024 SHALL hold off (pop=0) for every cycle out_almost_full=1 and resume on the first cycle it returns to 0 without losing pointer position.
REQ-025 SHALL complete an in-flight push registered before init/reset assertion only if reset=0; reset clears it.

Reset
REQ-026 SHALL, while reset=1: state=RESET, pop=0, push=0, data_out=0, grant_idx=3'b111, idle=0, pointer=RR_START.
REQ-027 SHALL, in INIT: reload pointer=RR_START, pop=0, push=0; data_out retained.

Configuration
REQ-028 SHALL, when macro VC_POP_SCHEDULER_STRICT_PRIORITY_EN is defined, replace round-robin with fixed priority (source 0 highest, 3 lowest), pointer unused; when undefined, round-robin per REQ-020.

Verification
REQ-029 Reset held 3 cycles, release -> state RESET, INIT, IDLE on successive edges; all outputs at REQ-026 values during reset.
REQ-030 fifo_empty=4'b0000 for 8 cycles, almost_full=0, RR_START=0 -> grant_idx 0,1,2,3,0,1,2,3; push each following cycle with matching data.
REQ-031 fifo_empty=4'b1010, pointer=1 -> grant source 2 then 0; fifo_empty=4'b1111 afterwards -> ACTIVE->IDLE, idle=1.
REQ-032 almost_full=1 for 4 cycles mid-stream after grant 1 -> pop=0, push=0 after one cycle; on release next grant=2.
REQ-033 init pulse while ACTIVE with grants pending -> state INIT next cycle, pointer=RR_START, then IDLE->ACTIVE resumes from RR_START.
REQ-034 With VC_POP_SCHEDULER_STRICT_PRIORITY_EN, fifo_empty=4'b0000 for 4 cycles -> grant_idx 0,0,0,0.

Source files
------------

// File: rtl/vc_pop_scheduler.sv
// rtl/vc_pop_scheduler.sv - pops one nonempty source FIFO per cycle into a destination FIFO.
// Round-robin by default; define VC_POP_SCHEDULER_STRICT_PRIORITY_EN for fixed priority (source 0 highest).
module vc_pop_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int RR_START   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  out_almost_full,
  output logic [3:0]            pop,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            grant_idx,
  output logic                  idle,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0]   din [4];
  logic                    pick_valid;
  logic [1:0]              pick_idx;
  logic                    pop_en;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;

`ifdef VC_POP_SCHEDULER_STRICT_PRIORITY_EN
  // Descending scan so the lowest nonempty index is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[k]) begin
        pick_valid = 1'b1;
        pick_idx   = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Same scan, but offsets are relative to the pointer so wrap 3->0 is free.
  always_comb begin
    logic [1:0] idx;
    idx        = 2'd0;
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (!fifo_empty[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (init || state_q == ST_INIT) begin
      ptr_d = 2'(RR_START);
    end else if (pop_en) begin
      ptr_d = pick_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'(RR_START);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // A pop in the init cycle would surface as a push during INIT, so init blocks it too.
  assign pop_en = (state_q == ST_ACTIVE) && !out_almost_full && !init && !reset && pick_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (fifo_empty != 4'b1111) state_d = ST_ACTIVE;
      ST_ACTIVE: if (fifo_empty == 4'b1111 && !pop_en) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
    if (init) begin
      state_d = ST_INIT;
    end
  end

  always_comb begin
    push_d     = pop_en;
    data_out_d = pop_en ? din[pick_idx] : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      push_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
    end
  end

  // Reset overrides outputs immediately, before the first edge has cleared the registers.
  always_comb begin
    pop       = pop_en ? (4'b0001 << pick_idx) : 4'b0000;
    grant_idx = pop_en ? {1'b0, pick_idx} : 3'b111;
    push      = push_q && !reset;
    data_out  = reset ? '0 : data_out_q;
    idle      = (state_q == ST_IDLE) && !reset;
    state     = reset ? ST_RESET : state_q;
  end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// tb/tb_vc_pop_scheduler.sv - scoreboard bench for vc_pop_scheduler (RR_START=0).
// Honours VC_POP_SCHEDULER_STRICT_PRIORITY_EN for expected grants.
module tb_vc_pop_scheduler;

  localparam int DW = 6;
  localparam logic [1:0] S_RESET = 2'b00, S_INIT = 2'b01, S_IDLE = 2'b10, S_ACT = 2'b11;
  localparam int NG = 7;

  logic          clk = 1'b0;
  logic          reset, init, out_almost_full;
  logic [3:0]    fifo_empty;
  logic [DW-1:0] din [4];
  logic [3:0]    pop;
  logic          push;
  logic [DW-1:0] data_out;
  logic [2:0]    grant_idx;
  logic          idle;
  logic [1:0]    state;

  logic [DW-1:0] exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  vc_pop_scheduler #(.DATA_WIDTH(DW), .RR_START(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .fifo_empty      (fifo_empty),
    .data_in_0       (din[0]),
    .data_in_1       (din[1]),
    .data_in_2       (din[2]),
    .data_in_3       (din[3]),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .grant_idx       (grant_idx),
    .idle            (idle),
    .state           (state)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_nonempty(input logic [3:0] fe);
    for (int i = 0; i < 4; i++) begin
      if (!fe[i]) return i;
    end
    return NG;
  endfunction

  // One clock cycle: drive at negedge, check 1ns later, edge follows.
  task automatic step(input logic rst, input logic ini, input logic [3:0] fe,
                      input logic af, input logic [1:0] st, input int g);
    int eg;
    eg = g;
`ifdef VC_POP_SCHEDULER_STRICT_PRIORITY_EN
    if (g != NG) eg = lowest_nonempty(fe);
`endif
    @(negedge clk);
    reset           = rst;
    init            = ini;
    fifo_empty      = fe;
    out_almost_full = af;
    for (int i = 0; i < 4; i++) din[i] = DW'($urandom_range(0, 63));
    #1;
    check_eq("state", int'(state), int'(st));
    check_eq("grant_idx", int'(grant_idx), eg);
    check_eq("pop", int'(pop), (eg == NG) ? 0 : (1 << eg));
    check_eq("idle", int'(idle), (st == S_IDLE && !rst) ? 1 : 0);
    if (rst) begin
      check_eq("push_rst", int'(push), 0);
      check_eq("data_out_rst", int'(data_out), 0);
      exp_q.delete();
    end else begin
      check_eq("push", int'(push), (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (push) check_eq("data_out", int'(data_out), int'(e));
      end
    end
    if (eg != NG) exp_q.push_back(din[eg]);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; fifo_empty = 4'b1111; out_almost_full = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;

    for (int i = 0; i < 3; i++) step(1, 0, 4'b1111, 0, S_RESET, NG);
    step(0, 0, 4'b1111, 0, S_RESET, NG);
    step(0, 0, 4'b1111, 0, S_INIT,  NG);
    step(0, 0, 4'b0000, 0, S_IDLE,  NG);
    for (int i = 0; i < 8; i++) step(0, 0, 4'b0000, 0, S_ACT, i % 4);
    step(0, 0, 4'b1111, 0, S_ACT,  NG);

    // Pointer to 1, then sources 0 and 2 only.
    step(0, 0, 4'b1110, 0, S_IDLE, NG);
    step(0, 0, 4'b1110, 0, S_ACT,  0);
    step(0, 0, 4'b1010, 0, S_ACT,  2);
    step(0, 0, 4'b1010, 0, S_ACT,  0);
    step(0, 0, 4'b1111, 0, S_ACT,  NG);
    step(0, 0, 4'b0000, 0, S_IDLE, NG);

    // Backpressure after grant 1.
    step(0, 0, 4'b0000, 0, S_ACT, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b0000, 1, S_ACT, NG);
    step(0, 0, 4'b0000, 0, S_ACT, 2);

    // Init with pointer at 3: restart must begin at RR_START.
    step(0, 1, 4'b0000, 0, S_ACT,  NG);
    step(0, 0, 4'b0000, 0, S_INIT, NG);
    step(0, 0, 4'b0000, 0, S_IDLE, NG);
    step(0, 0, 4'b0000, 0, S_ACT,  0);
    step(0, 0, 4'b0000, 0, S_ACT,  1);
    step(0, 0, 4'b1111, 0, S_ACT,  NG);
    step(0, 0, 4'b1111, 0, S_IDLE, NG);

    // Reset with a push in flight drops it.
    step(0, 0, 4'b1011, 0, S_IDLE,  NG);
    step(0, 0, 4'b1011, 0, S_ACT,   2);
    step(1, 0, 4'b1111, 0, S_RESET, NG);
    step(0, 0, 4'b1111, 0, S_RESET, NG);
    step(0, 0, 4'b1111, 0, S_INIT,  NG);
    step(0, 0, 4'b1111, 0, S_IDLE,  NG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
